// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared GPU constants and Object Memory DMA state encoding
package gpu_pkg;

  localparam int          VRAM_ADDR_WIDTH = 12;
  localparam logic [11:0] OBM_BASE        = 12'h800;
  localparam int          OBM_BYTES       = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/obm_dma.sv
// rtl/obm_dma.sv - copies one page of source memory into Object Memory, CPU writes take priority
module obm_dma #(
  parameter int                           VRAM_ADDR_WIDTH = gpu_pkg::VRAM_ADDR_WIDTH,
  parameter logic [VRAM_ADDR_WIDTH-1:0]   OBM_BASE        = VRAM_ADDR_WIDTH'(gpu_pkg::OBM_BASE),
  parameter int                           OBM_BYTES       = gpu_pkg::OBM_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       writable,
  input  logic                       start,
  input  logic                       abort,
  input  logic [7:0]                 src_page,
  output logic                       src_req,
  output logic [15:0]                src_addr,
  input  logic                       src_ack,
  input  logic [7:0]                 src_data,
  input  logic                       cpu_we,
  input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]                 cpu_data,
  output logic                       vram_we,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
  output logic [7:0]                 vram_data,
  output logic                       busy,
  output logic                       done
);

  import gpu_pkg::*;

  localparam logic [7:0] LAST_INDEX = 8'(OBM_BYTES - 1);

  dma_state_e                 r_state;
  logic [7:0]                 r_index;
  logic [7:0]                 r_page;
  logic [7:0]                 r_byte;
  logic                       r_src_req;
  logic                       r_busy;
  logic                       r_done;
  logic [VRAM_ADDR_WIDTH-1:0] r_last_addr;
  logic [7:0]                 r_last_data;

  logic                       w_abort_hit;
  logic                       w_dma_we;
  logic [VRAM_ADDR_WIDTH-1:0] w_dma_addr;

  // An abort only matters once a transfer is running; in IDLE it is dropped so start wins.
  assign w_abort_hit = abort && (r_state != ST_IDLE);
  // DMA owns the VRAM port only inside the write window and only when the CPU is silent.
  assign w_dma_we    = (r_state == ST_WRITE) && writable && !cpu_we && !abort;
  assign w_dma_addr  = OBM_BASE + VRAM_ADDR_WIDTH'(r_index);

  // Transfer sequencer: fetch a byte, wait for a write slot, advance until the page is copied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_index     <= 8'd0;
      r_page      <= 8'd0;
      r_byte      <= 8'd0;
      r_src_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_last_addr <= '0;
      r_last_data <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (w_dma_we) begin
        r_last_addr <= w_dma_addr;
        r_last_data <= r_byte;
      end
      if (w_abort_hit) begin
        r_state   <= ST_IDLE;
        r_src_req <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state   <= ST_FETCH;
              r_index   <= 8'd0;
              r_page    <= src_page;
              r_src_req <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (src_ack) begin
              r_byte    <= src_data;
              r_state   <= ST_WRITE;
              r_src_req <= 1'b0;
            end
          end
          ST_WRITE: begin
            if (w_dma_we) begin
              if (r_index == LAST_INDEX) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_index   <= r_index + 8'd1;
                r_state   <= ST_FETCH;
                r_src_req <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state   <= ST_IDLE;
            r_src_req <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign src_req  = r_src_req;
  assign src_addr = {r_page, r_index};
  assign busy     = r_busy;
  assign done     = r_done;

  // VRAM write mux: CPU passes straight through; idle cycles keep the last DMA address/data.
  always_comb begin
    vram_we      = 1'b0;
    vram_address = r_last_addr;
    vram_data    = r_last_data;
    if (cpu_we) begin
      vram_we      = 1'b1;
      vram_address = cpu_addr;
      vram_data    = cpu_data;
    end else if (w_dma_we) begin
      vram_we      = 1'b1;
      vram_address = w_dma_addr;
      vram_data    = r_byte;
    end
  end

endmodule

// File: tb/tb_obm_dma.sv
// tb/tb_obm_dma.sv - randomized self-checking bench for obm_dma
module tb_obm_dma;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        writable = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  src_page = 8'd0;
  logic        src_req;
  logic [15:0] src_addr;
  logic        src_ack = 1'b0;
  logic [7:0]  src_data = 8'd0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_addr = 12'd0;
  logic [7:0]  cpu_data = 8'd0;
  logic        vram_we;
  logic [11:0] vram_address;
  logic [7:0]  vram_data;
  logic        busy;
  logic        done;

  obm_dma #(.VRAM_ADDR_WIDTH(12), .OBM_BASE(12'h800), .OBM_BYTES(256)) dut (
    .clk(clk), .rst(rst), .writable(writable), .start(start), .abort(abort),
    .src_page(src_page), .src_req(src_req), .src_addr(src_addr),
    .src_ack(src_ack), .src_data(src_data),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .vram_we(vram_we), .vram_address(vram_address), .vram_data(vram_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source memory contents: byte k of page 0x40 is k ^ 0xA5, other pages differ.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h40;
  endfunction

  // Per-relative-cycle stimulus schedules for writable and CPU writes.
  bit wr_sched [0:4095];
  bit cpu_sched [0:4095];

  logic [19:0] wq[$];
  int done_cnt = 0, done_cyc = 0, cpu_err = 0, gate_err = 0, stab_err = 0;
  int lat_cfg = 0, ack_cnt = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0;
  logic [15:0] prev_addr = 16'd0;

  // Observer plus source responder acknowledging each request after lat_cfg waiting cycles.
  always @(negedge clk) begin
    if (vram_we && !cpu_we) begin
      wq.push_back({vram_address, vram_data});
      if (!writable) gate_err++;
    end
    if (cpu_we && (vram_we !== 1'b1 || vram_address !== cpu_addr || vram_data !== cpu_data)) cpu_err++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_req && !prev_ack && src_req && src_addr !== prev_addr) stab_err++;
    if (src_req) begin
      if (ack_cnt >= lat_cfg) begin
        src_ack = 1'b1;
        src_data = src_byte(src_addr);
        ack_cnt = 0;
      end else begin
        src_ack = 1'b0;
        ack_cnt++;
      end
    end else begin
      src_ack = 1'b0;
      ack_cnt = 0;
    end
    prev_req = src_req;
    prev_ack = src_ack;
    prev_addr = src_addr;
  end

  task automatic sched_clear();
    for (int i = 0; i < 4096; i++) begin
      wr_sched[i] = 1'b1;
      cpu_sched[i] = 1'b0;
    end
  endtask

  // Reference timing: one fetch cycle plus ack wait, then the write slot waits out blocked cycles.
  function automatic int model_done(input int lat);
    int t = 1;
    for (int k = 0; k < 256; k++) begin
      t += lat + 1;
      while ((!wr_sched[t] || cpu_sched[t]) && t < 4095) t++;
      t++;
    end
    return t;
  endfunction

  // Index of the first DMA write differing from a straight copy of the page, -1 if all n match.
  function automatic int first_diff(input logic [7:0] page, input int n);
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      a = {page, 8'(k)};
      if (k >= wq.size()) return k;
      if (wq[k] !== {OBM_BASE + 12'(k), src_byte(a)}) return k;
    end
    return -1;
  endfunction

  task automatic run_xfer(input logic [7:0] page, input int lat, input int abort_rel,
                          input int xs_rel, input logic [7:0] xs_page, output int done_rel);
    int t0, d0;
    wq.delete();
    lat_cfg = lat;
    d0 = done_cnt;
    done_rel = -1;
    @(posedge clk); #1;
    t0 = cyc;
    for (int rel = 0; rel < 4000; rel++) begin
      if (rel != 0) begin
        @(posedge clk); #1;
      end
      if (done_cnt != d0) begin
        done_rel = done_cyc - t0;
        break;
      end
      if (abort_rel > 0 && rel > abort_rel + 4) break;
      start    = (rel == 0) || (rel == xs_rel);
      src_page = (rel == xs_rel) ? xs_page : page;
      abort    = (rel == abort_rel);
      writable = wr_sched[rel];
      cpu_we   = cpu_sched[rel];
      cpu_addr = 12'($urandom);
      cpu_data = 8'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
    cpu_we = 1'b0;
    writable = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (src_req !== 1'b0) begin n_fail++; $display("FAIL reset_src_req: got %b expected 0", src_req); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (vram_we !== 1'b0) begin n_fail++; $display("FAIL reset_vram_we: got %b expected 0", vram_we); end
    n_checks++; if (src_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_src_addr: got %h expected 0000", src_addr); end
    cpu_we = 1'b1; cpu_addr = 12'h123; cpu_data = 8'h5A;
    #1;
    n_checks++;
    if (vram_we !== 1'b1 || vram_address !== 12'h123 || vram_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL reset_cpu_pass: got we=%b a=%h d=%h expected 1 123 5a", vram_we, vram_address, vram_data);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int d;
    sched_clear();
    run_xfer(8'h40, 0, -1, -1, 8'h00, d);
    n_checks++; if (d !== 513) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 513", d); end
    n_checks++; if (wq.size() !== 256) begin n_fail++; $display("FAIL basic_write_count: got %0d expected 256", wq.size()); end
    n_checks++; if (first_diff(8'h40, 256) !== -1) begin n_fail++; $display("FAIL basic_writes: first bad index %0d expected -1", first_diff(8'h40, 256)); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    n_checks++;
    if (vram_address !== 12'h8FF || vram_data !== src_byte(16'h40FF)) begin
      n_fail++;
      $display("FAIL basic_hold_last: got %h/%h expected 8ff/%h", vram_address, vram_data, src_byte(16'h40FF));
    end
  endtask

  task automatic test_cpu_priority();
    int d;
    sched_clear();
    for (int i = 10; i < 20; i++) cpu_sched[i] = 1'b1;
    run_xfer(8'h40, 0, -1, -1, 8'h00, d);
    n_checks++; if (d !== 523) begin n_fail++; $display("FAIL cpu_done_cycle: got %0d expected 523", d); end
    n_checks++; if (first_diff(8'h40, 256) !== -1 || wq.size() !== 256) begin n_fail++; $display("FAIL cpu_writes: first bad %0d count %0d expected -1 256", first_diff(8'h40, 256), wq.size()); end
    n_checks++; if (cpu_err !== 0) begin n_fail++; $display("FAIL cpu_passthrough: got %0d bad cycles expected 0", cpu_err); end
  endtask

  task automatic test_writable_pause();
    int d;
    sched_clear();
    for (int i = 13; i < 113; i++) wr_sched[i] = 1'b0;
    run_xfer(8'h40, 0, -1, -1, 8'h00, d);
    n_checks++; if (d !== 612) begin n_fail++; $display("FAIL pause_done_cycle: got %0d expected 612", d); end
    n_checks++; if (first_diff(8'h40, 256) !== -1 || wq.size() !== 256) begin n_fail++; $display("FAIL pause_writes: first bad %0d count %0d expected -1 256", first_diff(8'h40, 256), wq.size()); end
    n_checks++; if (gate_err !== 0) begin n_fail++; $display("FAIL pause_gating: got %0d writes outside window expected 0", gate_err); end
  endtask

  task automatic test_slow_ack();
    int d;
    sched_clear();
    run_xfer(8'h40, 3, -1, -1, 8'h00, d);
    n_checks++; if (d !== 1281) begin n_fail++; $display("FAIL slow_done_cycle: got %0d expected 1281", d); end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL slow_req_stable: got %0d address changes expected 0", stab_err); end
    n_checks++; if (first_diff(8'h40, 256) !== -1) begin n_fail++; $display("FAIL slow_writes: first bad %0d expected -1", first_diff(8'h40, 256)); end
  endtask

  task automatic test_start_while_busy();
    int d;
    sched_clear();
    run_xfer(8'h40, 0, -1, 50, 8'h33, d);
    n_checks++; if (d !== 513) begin n_fail++; $display("FAIL busy_start_done: got %0d expected 513", d); end
    n_checks++; if (first_diff(8'h40, 256) !== -1) begin n_fail++; $display("FAIL busy_start_page: first bad %0d expected -1", first_diff(8'h40, 256)); end
  endtask

  task automatic test_abort();
    int d;
    sched_clear();
    run_xfer(8'h40, 0, 201, -1, 8'h00, d);
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL abort_no_done: got done at %0d expected none", d); end
    n_checks++; if (wq.size() !== 100) begin n_fail++; $display("FAIL abort_write_count: got %0d expected 100", wq.size()); end
    n_checks++; if (first_diff(8'h40, 100) !== -1) begin n_fail++; $display("FAIL abort_partial: first bad %0d expected -1", first_diff(8'h40, 100)); end
    n_checks++; if (busy !== 1'b0 || src_req !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b req=%b expected 0 0", busy, src_req); end
    run_xfer(8'h20, 0, 0, -1, 8'h00, d);
    n_checks++; if (d !== 513) begin n_fail++; $display("FAIL abort_restart_done: got %0d expected 513", d); end
    n_checks++; if (first_diff(8'h20, 256) !== -1) begin n_fail++; $display("FAIL abort_restart_writes: first bad %0d expected -1", first_diff(8'h20, 256)); end
  endtask

  task automatic test_reset_mid();
    int d0, d;
    sched_clear();
    wq.delete();
    lat_cfg = 0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; src_page = 8'h40;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || src_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got busy=%b req=%b expected 0 0", busy, src_req); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    n_checks++; if (wq.size() !== 50) begin n_fail++; $display("FAIL rstmid_partial: got %0d writes expected 50", wq.size()); end
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d done pulses expected 0", done_cnt - d0); end
    n_checks++; if (src_addr !== 16'h0000) begin n_fail++; $display("FAIL rstmid_cleared: got %h expected 0000", src_addr); end
    run_xfer(8'h55, 0, -1, -1, 8'h00, d);
    n_checks++; if (d !== 513) begin n_fail++; $display("FAIL rstmid_restart_done: got %0d expected 513", d); end
    n_checks++; if (first_diff(8'h55, 256) !== -1) begin n_fail++; $display("FAIL rstmid_restart_writes: first bad %0d expected -1", first_diff(8'h55, 256)); end
  endtask

  task automatic test_random();
    int d, lat;
    logic [7:0] page;
    for (int it = 0; it < 3; it++) begin
      sched_clear();
      for (int i = 1; i < 4096; i++) begin
        wr_sched[i] = ($urandom_range(0, 7) != 0);
        cpu_sched[i] = ($urandom_range(0, 15) == 0);
      end
      lat = $urandom_range(0, 3);
      page = 8'($urandom);
      run_xfer(page, lat, -1, -1, 8'h00, d);
      n_checks++; if (d !== model_done(lat)) begin n_fail++; $display("FAIL rand%0d_done: got %0d expected %0d", it, d, model_done(lat)); end
      n_checks++; if (first_diff(page, 256) !== -1 || wq.size() !== 256) begin n_fail++; $display("FAIL rand%0d_writes: first bad %0d count %0d expected -1 256", it, first_diff(page, 256), wq.size()); end
    end
    n_checks++; if (cpu_err !== 0 || gate_err !== 0 || stab_err !== 0) begin n_fail++; $display("FAIL rand_protocol: got cpu=%0d gate=%0d stab=%0d expected 0 0 0", cpu_err, gate_err, stab_err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_cpu_priority();
    test_writable_pause();
    test_slow_ack();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
